// File: rtl/uart_access_arbiter_pkg.sv
// Shared types for the UART register-access arbiter: the UART register map,
// the arbiter FSM states and the default done-timeout.
package uart_pkg;

    // UART register addresses as seen on the shared access port.
    typedef enum logic [2:0] {
        UART_CTRL      = 3'd0,
        UART_STATUS    = 3'd1,
        UART_DIVIDER   = 3'd2,
        UART_TX_BUFFER = 3'd3,
        UART_RX_BUFFER = 3'd4
    } uart_registers_t;

    // Arbiter sequencing: pick a requester, strobe once, wait for done.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } uart_arb_state_t;

    localparam int UART_ARB_DEFAULT_TIMEOUT = 15;
    localparam int UART_DATA_W              = 32;

endpackage

// File: rtl/uart_access_arbiter_if.sv
// UART-side register access bus. The arbiter drives the strobes, address and
// write data (master); the UART returns done/error and read data (slave).
interface uart_access_arbiter_if;
    import uart_pkg::*;

    logic                   uart_write_o;
    logic                   uart_read_o;
    uart_registers_t        uart_address_o;
    logic [UART_DATA_W-1:0] uart_write_data_o;
    logic                   uart_write_done_i;
    logic                   uart_write_error_i;
    logic                   uart_read_done_i;
    logic                   uart_read_error_i;
    logic [UART_DATA_W-1:0] uart_read_data_i;

    modport master (
        output uart_write_o,
        output uart_read_o,
        output uart_address_o,
        output uart_write_data_o,
        input  uart_write_done_i,
        input  uart_write_error_i,
        input  uart_read_done_i,
        input  uart_read_error_i,
        input  uart_read_data_i
    );

    modport slave (
        input  uart_write_o,
        input  uart_read_o,
        input  uart_address_o,
        input  uart_write_data_o,
        output uart_write_done_i,
        output uart_write_error_i,
        output uart_read_done_i,
        output uart_read_error_i,
        output uart_read_data_i
    );

endinterface

// File: rtl/uart_access_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first eligible index found
// when searching upward from rr_last+1, wrapping at N.
module uart_rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] rr_last,
    output logic          valid,
    output logic [IW-1:0] index
);

    // cand_idx[k] is the requester checked at search position k (k=0 first).
    logic [N-1:0][IW-1:0] cand_idx;
    logic [N-1:0]         cand_hit;

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        localparam int OFS = gi + 1;
        logic [31:0] sum;

        // Explicit compare for the wrap so non-power-of-2 N works.
        assign sum          = 32'(rr_last) + OFS;
        assign cand_idx[gi] = (sum >= 32'(N)) ? IW'(sum - 32'(N)) : IW'(sum);
        assign cand_hit[gi] = eligible[cand_idx[gi]];
    end

    assign valid = |cand_hit;

    // Lowest search position wins; scan from the far end so it overrides.
    always_comb begin
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                index = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/uart_access_arbiter.sv
// Round-robin arbiter sharing one UART register-access port between several
// bus masters. One transaction at a time: grant, one-cycle strobe, wait for
// the matching done (or a timeout), then a one-cycle done_o to the owner.
module uart_access_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int TIMEOUT_CYCLES = UART_ARB_DEFAULT_TIMEOUT
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NUM_REQUESTERS-1:0]                 req_i,
    input  logic [NUM_REQUESTERS-1:0]                 we_i,
    input  uart_registers_t [NUM_REQUESTERS-1:0]      addr_i,
    input  logic [NUM_REQUESTERS-1:0][UART_DATA_W-1:0] wdata_i,
    output logic [NUM_REQUESTERS-1:0]                 done_o,
    output logic [NUM_REQUESTERS-1:0]                 error_o,
    output logic [NUM_REQUESTERS-1:0][UART_DATA_W-1:0] rdata_o,
    uart_access_arbiter_if.master                     uart
);

    localparam int IDX_W   = $clog2(NUM_REQUESTERS);
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    uart_arb_state_t        state_reg,   state_next;
    logic [IDX_W-1:0]       gnt_idx_reg, gnt_idx_next;
    logic [IDX_W-1:0]       rr_last_reg, rr_last_next;
    logic [TIMER_W-1:0]     timer_reg,   timer_next;
    logic                   we_reg,      we_next;
    uart_registers_t        addr_reg,    addr_next;
    logic [UART_DATA_W-1:0] wdata_reg,   wdata_next;

    logic [NUM_REQUESTERS-1:0]                  done_reg,  done_next;
    logic [NUM_REQUESTERS-1:0]                  error_reg, error_next;
    logic [NUM_REQUESTERS-1:0][UART_DATA_W-1:0] rdata_reg, rdata_next;

    logic [NUM_REQUESTERS-1:0] eligible;
    logic                      pick_valid;
    logic [IDX_W-1:0]          pick_index;

    logic                   uart_done;
    logic                   uart_err;
    logic                   finish;
    logic                   finish_err;
    logic [UART_DATA_W-1:0] finish_data;

    // A requester whose done_o is high this cycle is still holding req from
    // the finished transaction, so it must not be re-granted yet.
    assign eligible = req_i & ~done_reg;

    uart_rr_picker #(
        .N  (NUM_REQUESTERS),
        .IW (IDX_W)
    ) u_picker (
        .eligible (eligible),
        .rr_last  (rr_last_reg),
        .valid    (pick_valid),
        .index    (pick_index)
    );

    // Only the done/error of the access type we issued counts.
    assign uart_done = we_reg ? uart.uart_write_done_i  : uart.uart_read_done_i;
    assign uart_err  = we_reg ? uart.uart_write_error_i : uart.uart_read_error_i;

    // Strobe lives only in ISSUE so a RX-buffer read pops exactly once.
    assign uart.uart_write_o      = (state_reg == ISSUE) &&  we_reg;
    assign uart.uart_read_o       = (state_reg == ISSUE) && !we_reg;
    assign uart.uart_address_o    = addr_reg;
    assign uart.uart_write_data_o = wdata_reg;

    assign done_o  = done_reg;
    assign error_o = error_reg;
    assign rdata_o = rdata_reg;

    // Next-state logic: arbitration, strobe sequencing and timeout.
    always_comb begin
        state_next   = state_reg;
        gnt_idx_next = gnt_idx_reg;
        rr_last_next = rr_last_reg;
        timer_next   = timer_reg;
        we_next      = we_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        finish       = 1'b0;
        finish_err   = 1'b0;
        finish_data  = '0;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    gnt_idx_next = pick_index;
                    rr_last_next = pick_index;
                    we_next      = we_i[pick_index];
                    addr_next    = addr_i[pick_index];
                    wdata_next   = wdata_i[pick_index];
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                if (uart_done) begin
                    finish      = 1'b1;
                    finish_err  = uart_err;
                    finish_data = uart.uart_read_data_i;
                    state_next  = IDLE;
                end else begin
                    timer_next = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (uart_done) begin
                    finish      = 1'b1;
                    finish_err  = uart_err;
                    finish_data = uart.uart_read_data_i;
                    state_next  = IDLE;
                end else if (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    finish      = 1'b1;
                    finish_err  = 1'b1;
                    finish_data = '0;
                    state_next  = IDLE;
                end else begin
                    timer_next = timer_reg + TIMER_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Response: one-cycle done/error to the owner; read data sticks per requester.
    always_comb begin
        done_next  = '0;
        error_next = '0;
        rdata_next = rdata_reg;
        if (finish) begin
            done_next[gnt_idx_reg]  = 1'b1;
            error_next[gnt_idx_reg] = finish_err;
            if (!we_reg) begin
                rdata_next[gnt_idx_reg] = finish_data;
            end
        end
    end

    // State and response registers; reset drops any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            gnt_idx_reg <= '0;
            rr_last_reg <= IDX_W'(NUM_REQUESTERS - 1);
            timer_reg   <= '0;
            we_reg      <= 1'b0;
            addr_reg    <= UART_CTRL;
            wdata_reg   <= '0;
            done_reg    <= '0;
            error_reg   <= '0;
            rdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            gnt_idx_reg <= gnt_idx_next;
            rr_last_reg <= rr_last_next;
            timer_reg   <= timer_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            done_reg    <= done_next;
            error_reg   <= error_next;
            rdata_reg   <= rdata_next;
        end
    end

endmodule

// File: tb/tb_uart_access_arbiter.sv
// Directed bench for uart_access_arbiter (N=4, timeout 15). A tiny UART model
// either ties done to the strobe or is driven by hand for delayed/absent done.
module tb_uart_access_arbiter;
    import uart_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic [3:0]            req_i = '0;
    logic [3:0]            we_i  = '0;
    uart_registers_t [3:0] addr_i;
    logic [3:0][31:0]      wdata_i = '0;
    logic [3:0]            done_o;
    logic [3:0]            error_o;
    logic [3:0][31:0]      rdata_o;

    logic        tie_wr    = 1'b0;
    logic        tie_rd    = 1'b0;
    logic        man_wdone = 1'b0;
    logic        man_rdone = 1'b0;
    logic        werr      = 1'b0;
    logic        rerr      = 1'b0;
    logic [31:0] rd_data   = '0;

    int check_count = 0;
    int error_count = 0;

    uart_access_arbiter_if uif();

    assign uif.uart_write_done_i  = (tie_wr & uif.uart_write_o) | man_wdone;
    assign uif.uart_read_done_i   = (tie_rd & uif.uart_read_o)  | man_rdone;
    assign uif.uart_write_error_i = werr;
    assign uif.uart_read_error_i  = rerr;
    assign uif.uart_read_data_i   = rd_data;

    uart_access_arbiter #(
        .NUM_REQUESTERS (4),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .done_o  (done_o),
        .error_o (error_o),
        .rdata_o (rdata_o),
        .uart    (uif.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance n clock edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [3:0] seen;
        logic [3:0] exp_order [5];
        bit         got_done;
        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000;
        exp_order[4] = 4'b0001;
        for (int i = 0; i < 4; i++) addr_i[i] = UART_CTRL;

        // ---------------- reset state ----------------
        step(2);
        rst_i = 1'b0;
        check_value("rst_done",  32'(done_o), 32'h0);
        check_value("rst_error", 32'(error_o), 32'h0);
        check_value("rst_wr",    32'(uif.uart_write_o), 32'h0);
        check_value("rst_rd",    32'(uif.uart_read_o), 32'h0);
        check_value("rst_addr",  32'(uif.uart_address_o), 32'h0);
        check_value("rst_wdata", uif.uart_write_data_o, 32'h0);

        // ---------------- single write, requester 2 ----------------
        tie_wr = 1'b1;
        req_i = 4'b0100; we_i = 4'b0100;
        addr_i[2] = UART_DIVIDER; wdata_i[2] = 32'h0000_0145;
        step(1); // cycle 1
        check_value("wr_strobe",  32'(uif.uart_write_o), 32'h1);
        check_value("wr_nord",    32'(uif.uart_read_o), 32'h0);
        check_value("wr_addr",    32'(uif.uart_address_o), 32'(UART_DIVIDER));
        check_value("wr_data",    uif.uart_write_data_o, 32'h0000_0145);
        check_value("wr_early",   32'(done_o), 32'h0);
        step(1); // cycle 2
        check_value("wr_done",    32'(done_o), 32'h4);
        check_value("wr_err",     32'(error_o), 32'h0);
        check_value("wr_strobe1", 32'(uif.uart_write_o), 32'h0);
        check_value("wr_hold",    32'(uif.uart_address_o), 32'(UART_DIVIDER));
        $display("txn write req2 addr=DIVIDER data=0x145 done=%b err=%b", done_o, error_o);
        req_i = '0;
        step(1);
        check_value("wr_pulse",   32'(done_o), 32'h0);

        // ---------------- RX-buffer read, done one cycle late ----------------
        tie_wr = 1'b0;
        req_i = 4'b0001; we_i = 4'b0000; addr_i[0] = UART_RX_BUFFER;
        step(1); // cycle 1
        check_value("rx_strobe",  32'(uif.uart_read_o), 32'h1);
        check_value("rx_addr",    32'(uif.uart_address_o), 32'(UART_RX_BUFFER));
        step(1); // cycle 2
        check_value("rx_strobe1", 32'(uif.uart_read_o), 32'h0);
        check_value("rx_early",   32'(done_o), 32'h0);
        man_rdone = 1'b1; rd_data = 32'h0000_005A;
        step(1); // cycle 3
        man_rdone = 1'b0;
        check_value("rx_done",    32'(done_o), 32'h1);
        check_value("rx_err",     32'(error_o), 32'h0);
        check_value("rx_data",    rdata_o[0], 32'h0000_005A);
        $display("txn read req0 addr=RX_BUFFER rdata=0x%08h done=%b", rdata_o[0], done_o);
        req_i = '0;
        step(1);
        check_value("rx_pulse",   32'(done_o), 32'h0);
        check_value("rx_hold",    rdata_o[0], 32'h0000_005A);

        // ---------------- four requesters from reset ----------------
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        tie_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr_i[i]  = UART_TX_BUFFER;
            wdata_i[i] = 32'(i + 16);
        end
        we_i = 4'b1111; req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            got_done = 1'b0;
            for (int c = 0; c < 10; c++) begin
                step(1);
                if (done_o != 4'b0) begin
                    got_done = 1'b1;
                    break;
                end
            end
            seen = done_o;
            check_value("rr_order", 32'(seen), 32'(exp_order[k]));
            $display("txn rr grant %0d done=%b (found=%0d)", k, seen, got_done);
            if (k == 4) req_i = '0;
        end
        step(3);

        // ---------------- read by req1 to seed rdata, then timeout ----------------
        tie_wr = 1'b0; tie_rd = 1'b1;
        rd_data = 32'hDEAD_BEEF;
        req_i = 4'b0010; we_i = 4'b0000; addr_i[1] = UART_STATUS;
        step(2);
        check_value("seed_done", 32'(done_o), 32'h2);
        check_value("seed_data", rdata_o[1], 32'hDEAD_BEEF);
        $display("txn read req1 addr=STATUS rdata=0x%08h", rdata_o[1]);
        req_i = '0;
        step(1);
        tie_rd = 1'b0;
        req_i = 4'b0010; // cycle 0
        step(16);        // cycle 16
        check_value("to_early", 32'(done_o), 32'h0);
        step(1);         // cycle 17
        check_value("to_done",  32'(done_o), 32'h2);
        check_value("to_err",   32'(error_o), 32'h2);
        check_value("to_data",  rdata_o[1], 32'h0);
        $display("txn read req1 timeout done=%b err=%b", done_o, error_o);
        req_i = 4'b0100; we_i = 4'b0100; wdata_i[2] = 32'h0000_A5A5;
        tie_wr = 1'b1;
        step(2);
        check_value("after_to_done", 32'(done_o), 32'h4);
        check_value("after_to_err",  32'(error_o), 32'h0);
        $display("txn write req2 after timeout done=%b err=%b", done_o, error_o);
        req_i = '0;
        step(1);

        // ---------------- UART write error passthrough ----------------
        werr = 1'b1;
        req_i = 4'b1000; we_i = 4'b1000; wdata_i[3] = 32'h0000_0033;
        step(2);
        check_value("werr_done", 32'(done_o), 32'h8);
        check_value("werr_err",  32'(error_o), 32'h8);
        $display("txn write req3 uart error done=%b err=%b", done_o, error_o);
        req_i = '0; werr = 1'b0;
        step(1);
        check_value("werr_done1", 32'(done_o), 32'h0);
        check_value("werr_err1",  32'(error_o), 32'h0);

        // ---------------- reset during a pending read ----------------
        tie_wr = 1'b0; tie_rd = 1'b0;
        req_i = 4'b0100; we_i = 4'b0000;
        addr_i[2] = UART_RX_BUFFER; wdata_i[2] = 32'h0000_0077;
        step(2); // cycle 2, in WAIT
        check_value("rstw_addr", 32'(uif.uart_address_o), 32'(UART_RX_BUFFER));
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0; req_i = '0;
        check_value("rstw_done",  32'(done_o), 32'h0);
        check_value("rstw_rd",    32'(uif.uart_read_o), 32'h0);
        check_value("rstw_addr0", 32'(uif.uart_address_o), 32'h0);
        check_value("rstw_wdata", uif.uart_write_data_o, 32'h0);
        check_value("rstw_rdata", rdata_o[1], 32'h0);
        seen = '0;
        for (int c = 0; c < 4; c++) begin
            step(1);
            seen = seen | done_o;
        end
        check_value("rstw_nodone", 32'(seen), 32'h0);
        tie_wr = 1'b1;
        req_i = 4'b1001; we_i = 4'b1001;
        step(2);
        check_value("rstw_next", 32'(done_o), 32'h1);
        $display("txn after reset first grant done=%b", done_o);
        req_i = '0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
